// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared declarations for the serial adder/subtractor.
// Holds the control state encoding and the a_ns mode constants.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas.sv
// fas_bit: one-bit combinational full adder/subtractor cell.
// In subtract mode the B input is inverted; the caller presets the carry
// to 1 so the slice chain forms A + ~B + 1.
module fas_bit
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic b_eff;

  assign b_eff = (a_ns == MODE_ADD) ? b : ~b;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial (or digit-serial) two's-complement adder/subtractor.
// Operands are captured on the in_valid/in_ready handshake, then processed
// BITS_PER_CYCLE bits per clock, LSB first, with the carry held in a register
// between slices. done pulses for one cycle when result/cout/ovf are valid.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables the signed overflow
// flag; without it ovf is tied low and no overflow logic exists.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_ns,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  // Elaboration-time parameter sanity checks.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_addsub: WIDTH must be at least 2");
    end
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("serial_addsub: WIDTH must be a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  state_t               state_reg;
  state_t               state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic                 mode_reg;
  logic                 carry_reg;
  logic [CNT_W-1:0]     slice_reg;
  logic [WIDTH-1:0]     result_reg;
  logic                 cout_reg;

  logic                      accept;
  logic                      last_slice;
  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic [WIDTH-1:0]          result_shift;

  assign accept     = in_valid && (state_reg == IDLE);
  assign last_slice = (state_reg == RUN) && (slice_reg == LAST_SLICE);
  assign chain[0]   = carry_reg;

  // Ripple chain across the bits of one slice; the bottom bits of the
  // operand shift registers are always the next unprocessed slice.
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_slice
      fas_bit u_bit (
        .a    (a_reg[gi]),
        .b    (b_reg[gi]),
        .cin  (chain[gi]),
        .a_ns (mode_reg),
        .s    (slice_sum[gi]),
        .cout (chain[gi+1])
      );
    end
  endgenerate

  // Result fills from the top so the first slice ends up at the LSB
  // after N shifts.
  generate
    if (BITS_PER_CYCLE == WIDTH) begin : g_res_full
      assign result_shift = slice_sum;
    end else begin : g_res_shift
      assign result_shift = {slice_sum, result_reg[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN for N slices, one DONE cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (slice_reg == LAST_SLICE) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, then one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      mode_reg   <= MODE_ADD;
      carry_reg  <= 1'b0;
      slice_reg  <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b;
      mode_reg  <= a_ns;
      carry_reg <= ~a_ns;
      slice_reg <= '0;
    end else if (state_reg == RUN) begin
      a_reg      <= a_reg >> BITS_PER_CYCLE;
      b_reg      <= b_reg >> BITS_PER_CYCLE;
      carry_reg  <= chain[BITS_PER_CYCLE];
      slice_reg  <= slice_reg + CNT_W'(1);
      result_reg <= result_shift;
      if (last_slice) begin
        cout_reg <= chain[BITS_PER_CYCLE];
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (last_slice) begin
      ovf_reg <= chain[BITS_PER_CYCLE-1] ^ chain[BITS_PER_CYCLE];
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign result   = result_reg;
  assign cout     = cout_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized self-checking bench for serial_addsub.
// Two instances (1 and 4 bits per cycle) share stimulus; sel picks which
// one receives in_valid and whose outputs are checked.
`timescale 1ns/1ps
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         a_ns;

  logic         iv1, iv4;
  logic         rdy1, rdy4, cout1, cout4, ovf1, ovf4, done1, done4, busy1, busy4;
  logic [W-1:0] res1, res4;

  logic         rdy_s, cout_s, ovf_s, done_s, busy_s;
  logic [W-1:0] res_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign iv1 = in_valid & ~sel;
  assign iv4 = in_valid & sel;

  serial_addsub #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
    .a(a), .b(b), .a_ns(a_ns), .result(res1), .cout(cout1),
    .ovf(ovf1), .done(done1), .busy(busy1)
  );

  serial_addsub #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
    .a(a), .b(b), .a_ns(a_ns), .result(res4), .cout(cout4),
    .ovf(ovf4), .done(done4), .busy(busy4)
  );

  assign rdy_s  = sel ? rdy4  : rdy1;
  assign res_s  = sel ? res4  : res1;
  assign cout_s = sel ? cout4 : cout1;
  assign ovf_s  = sel ? ovf4  : ovf1;
  assign done_s = sel ? done4 : done1;
  assign busy_s = sel ? busy4 : busy1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode,
                                 output logic [W-1:0] r, output logic c, output logic v);
    int sx, sy, st;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (mode) begin
      r  = W'(int'(x) + int'(y));
      c  = (int'(x) + int'(y)) > 255;
      st = sx + sy;
    end else begin
      r  = W'(int'(x) - int'(y));
      c  = (x >= y);
      st = sx - sy;
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    v = (st > 127) || (st < -128);
`else
    v = 1'b0;
`endif
  endfunction

  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic mode, input bit junk, input string name);
    int n;
    int k;
    bit seen;
    logic [W-1:0] er;
    logic ec, ev;
    n = s ? 2 : 8;
    ref_op(x, y, mode, er, ec, ev);
    @(negedge clk);
    sel = s; a = x; b = y; a_ns = mode; in_valid = 1'b1;
    check_val({name, "_ready"}, 32'(rdy_s), 32'd1);
    @(posedge clk); #1;
    if (!junk) in_valid = 1'b0;
    k = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      if (junk) begin
        a = W'($urandom); b = W'($urandom); a_ns = 1'($urandom);
      end
      @(posedge clk); #1;
      k++;
      if (done_s) seen = 1'b1;
      else check_val({name, "_busy_run"}, {30'd0, busy_s, rdy_s}, 32'h2);
    end
    in_valid = 1'b0;
    check_val({name, "_done_seen"}, 32'(seen), 32'd1);
    check_val({name, "_latency"}, k, n);
    check_val({name, "_result"}, 32'(res_s), 32'(er));
    check_val({name, "_cout"}, 32'(cout_s), 32'(ec));
    check_val({name, "_ovf"}, 32'(ovf_s), 32'(ev));
    check_val({name, "_busy_done"}, 32'(busy_s), 32'd1);
    @(posedge clk); #1;
    check_val({name, "_idle_flags"}, {29'd0, done_s, busy_s, rdy_s}, 32'h1);
    check_val({name, "_hold"}, {23'd0, ovf_s, cout_s, res_s}, {23'd0, ev, ec, er});
    $display("op %s sel=%0d a=0x%02h b=0x%02h add=%0d -> result=0x%02h cout=%0d ovf=%0d lat=%0d",
             name, s, x, y, mode, res_s, cout_s, ovf_s, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; a = '0; b = '0; a_ns = 1'b1;
    #12;
    check_val("reset_dut1", {21'd0, res1, cout1, ovf1, done1, busy1}, 32'd0);
    check_val("reset_dut4", {21'd0, res4, cout4, ovf4, done4, busy4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 8'h7F, 8'h01, 1'b1, 1'b0, "add_7f_01");
    run_op(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, "sub_00_01");
    run_op(1'b0, 8'h05, 8'h03, 1'b0, 1'b0, "sub_05_03");
    run_op(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, "add4_ff_ff");
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b0, "sub4_80_01");
    run_op(1'b0, 8'h3C, 8'h5A, 1'b1, 1'b1, "junk_dut1");
    run_op(1'b0, 8'h11, 8'h22, 1'b1, 1'b0, "after_junk");
    run_op(1'b1, 8'hC3, 8'h7E, 1'b0, 1'b1, "junk_dut4");

    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    // Reset in the middle of RUN.
    @(negedge clk);
    sel = 1'b0; a = 8'h5A; b = 8'h33; a_ns = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midreset_outputs", {21'd0, res1, cout1, ovf1, done1, busy1}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("midreset_no_done", {30'd0, done1, busy1}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 8'h5A, 8'h33, 1'b1, 1'b0, "post_reset");
    run_op(1'b0, 8'h7F, 8'h01, 1'b1, 1'b0, "add_7f_01_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
